// File: rtl/seq_cmp_pkg.sv
// Shared encodings for the sequential set-compare unit.
//
// Contents:
//   op_t    : operation select (SLT, SLTU, SEQ, SNE), matches the 2-bit op port
//   state_t : scan FSM states (IDLE, SCAN, DONE)
//   flag_of : maps the scan outcome (decided, lt) to the result flag for an op
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        OP_SLT  = 2'b00,
        OP_SLTU = 2'b01,
        OP_SEQ  = 2'b10,
        OP_SNE  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // decided == 1 means at least one chunk differed, so the operands are unequal.
    function automatic logic flag_of(input op_t op, input logic decided, input logic lt);
        logic f;
        f = 1'b0;
        case (op)
            OP_SLT, OP_SLTU: f = lt;
            OP_SEQ:          f = ~decided;
            OP_SNE:          f = decided;
            default:         f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/seq_set_less_than_cmp_chunk.sv
// Combinational chunk comparator for seq_set_less_than.
//
// Ports:
//   a, b       in  W  chunk of operand A / B
//   signed_top in  1  chunk holds the operand sign bit of a signed compare;
//                     its MSB is inverted on both sides so an unsigned
//                     compare yields two's-complement ordering
//   eq         out 1  chunks are bit-identical
//   lt         out 1  a < b after the MSB adjustment
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_top,
    output logic         eq,
    output logic         lt
);

    logic [W-1:0] flip;
    logic [W-1:0] a_adj;
    logic [W-1:0] b_adj;

    always_comb begin
        flip        = '0;
        flip[W-1]   = signed_top;
    end

    assign a_adj = a ^ flip;
    assign b_adj = b ^ flip;

    // Flipping the same bit on both sides never changes equality.
    assign eq = (a == b);
    assign lt = (a_adj < b_adj);

endmodule

// File: rtl/seq_set_less_than.sv
// Multi-cycle set-compare unit (SLT / SLTU / SEQ / SNE) for the RISC ALU.
// Operands are compared one CHUNK-bit slice per cycle, most significant
// slice first, through a single shared cmp_chunk instance.
//
// Parameters:
//   N      operand/result width, multiple of CHUNK
//   CHUNK  bits compared per cycle
//
// Ports:
//   clk        in  1  system clock (rising edge)
//   rst_n      in  1  asynchronous active-low reset
//   in_valid   in  1  a, b, op presented
//   in_ready   out 1  unit idle and able to accept
//   a, b       in  N  operands
//   op         in  2  00 SLT, 01 SLTU, 10 SEQ, 11 SNE
//   out_valid  out 1  result valid
//   out_ready  in  1  consumer takes the result
//   result     out N  {N-1 zeros, flag}
//   busy       out 1  scanning or holding a result
//
// Build option:
//   SEQ_CMP_EARLY_EXIT_EN  when defined, the scan stops at the first differing
//                          chunk; otherwise it always runs NCHUNK cycles.
//                          Results are the same either way.
module seq_set_less_than
    import seq_cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int NCHUNK = N / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_t            state_q;
    state_t            state_d;

    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;
    op_t               op_q;
    logic [IDXW-1:0]   idx_q;
    logic              decided_q;
    logic              lt_q;
    logic [N-1:0]      result_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic              signed_top;
    logic              chunk_eq;
    logic              chunk_lt;
    logic              first_diff;
    logic              decided_d;
    logic              lt_d;
    logic              scan_last;
    logic [N-1:0]      result_d;

    // ------------------------------------------------------------------
    // Chunk selection and comparison
    // ------------------------------------------------------------------
    always_comb begin
        a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];
    end

    assign signed_top = (idx_q == IDX_TOP) && (op_q == OP_SLT);

    cmp_chunk #(
        .W (CHUNK)
    ) u_cmp (
        .a          (a_chunk),
        .b          (b_chunk),
        .signed_top (signed_top),
        .eq         (chunk_eq),
        .lt         (chunk_lt)
    );

    // Only the first differing chunk (from the top) decides the ordering;
    // later chunks are ignored once decided is set.
    assign first_diff = ~chunk_eq & ~decided_q;
    assign decided_d  = decided_q | ~chunk_eq;
    assign lt_d       = first_diff ? chunk_lt : lt_q;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign scan_last = first_diff || (idx_q == '0);
`else
    assign scan_last = (idx_q == '0);
`endif

    always_comb begin
        result_d    = '0;
        result_d[0] = flag_of(op_q, decided_d, lt_d);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_SCAN;
            ST_SCAN: if (scan_last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, scan and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_SLT;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op_t'(op);
                        idx_q     <= IDX_TOP;
                        decided_q <= 1'b0;
                        lt_q      <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    decided_q <= decided_d;
                    lt_q      <= lt_d;
                    if (scan_last) begin
                        result_q <= result_d;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_seq_set_less_than.sv
module tb_seq_set_less_than;

    localparam int N      = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = N / CHUNK;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         busy;

    seq_set_less_than #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] res;
        int           lat;
        int           acc;
        int           bp;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic on whole operands; latency from the
    // position of the first differing chunk counted from the top.
    function automatic void model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                                  output logic [N-1:0] r, output int lat);
        logic f;
        int   first;
        case (o)
            2'b00:   f = ($signed(x) < $signed(y));
            2'b01:   f = (x < y);
            2'b10:   f = (x == y);
            default: f = (x != y);
        endcase
        r = '0;
        r[0] = f;
        first = -1;
        for (int k = 0; k < NCHUNK; k++) begin
            if (first < 0 && x[(NCHUNK-1-k)*CHUNK +: CHUNK] != y[(NCHUNK-1-k)*CHUNK +: CHUNK])
                first = k;
        end
        lat = NCHUNK;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (first >= 0) lat = first + 1;
`endif
    endfunction

    // Called at a negedge. Holds the request until in_ready, then pushes the
    // expectation and scrambles the operand bus after the accept edge.
    task automatic send(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] req, input int bp);
        int   n;
        int   lat;
        exp_t e;
        logic [N-1:0] mr;
        n = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        model(o, x, y, mr, lat);
        e.res = req;
        e.lat = lat;
        e.acc = cyc + 1;
        e.bp  = bp;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        op = 2'($urandom);
    endtask

    task automatic send_rand(input int bp);
        logic [1:0]   o;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] r;
        int           lat;
        o = 2'($urandom);
        x = N'($urandom);
        case ($urandom_range(0, 3))
            0:       y = x;
            1:       y = x ^ (N'(1) << $urandom_range(0, N-1));
            default: y = N'($urandom);
        endcase
        model(o, x, y, r, lat);
        send(o, x, y, r, bp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (sbq.size() == 0 && !out_valid) ? 1 : 0, 1);
    endtask

    // Monitor: pops on the first cycle a result is presented, then checks it
    // stays stable under backpressure before pulsing out_ready.
    initial begin : monitor
        exp_t cur;
        logic seen;
        logic hs_pending;
        int   wait_left;
        seen = 1'b0;
        hs_pending = 1'b0;
        wait_left = 0;
        cur.res = '0; cur.lat = 0; cur.acc = 0; cur.bp = 0;
        forever begin
            @(negedge clk);
            out_ready = 1'b0;
            if (hs_pending) begin
                check("post_hs_out_valid", out_valid, 0);
                check("post_hs_in_ready", in_ready, 1);
                hs_pending = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_output", 1, 0);
                        wait_left = 0;
                    end else begin
                        cur = sbq.pop_front();
                        check("result", result, cur.res);
                        check("latency", cyc - cur.acc, cur.lat);
                        wait_left = (cur.bp >= 0) ? cur.bp : $urandom_range(0, 2);
                    end
                    seen = 1'b1;
                end else begin
                    check("hold_result", result, cur.res);
                    check("hold_in_ready", in_ready, 0);
                    check("hold_busy", busy, 1);
                end
                if (wait_left == 0) begin
                    out_ready  = 1'b1;
                    hs_pending = 1'b1;
                    seen       = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with fixed expected flags; first one under backpressure.
        send(2'b00, 8'hF0, 8'h05, 8'h01, 3);
        send(2'b01, 8'hF0, 8'h05, 8'h00, -1);
        send(2'b00, 8'h7F, 8'h80, 8'h00, -1);
        send(2'b01, 8'h7F, 8'h80, 8'h01, -1);
        send(2'b10, 8'h5A, 8'h5A, 8'h01, -1);
        send(2'b11, 8'h5A, 8'h5B, 8'h01, -1);
        send(2'b00, 8'h3C, 8'h3C, 8'h00, -1);
        send(2'b01, 8'hA5, 8'hA5, 8'h00, -1);
        send(2'b11, 8'hA5, 8'hA5, 8'h00, -1);
        send(2'b00, 8'h80, 8'h7F, 8'h01, -1);
        drain();

        // Randomized back-to-back traffic with random idle gaps and stalls.
        for (int i = 0; i < 150; i++) begin
            send_rand(-1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        // Leave a nonzero result behind, then reset during the second SCAN cycle.
        send(2'b11, 8'h5A, 8'h5B, 8'h01, 0);
        drain();
        op = 2'b10; a = 8'h33; b = 8'h33; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midscan_rst_out_valid", out_valid, 0);
        check("midscan_rst_in_ready", in_ready, 1);
        check("midscan_rst_result", result, 0);
        check("midscan_rst_busy", busy, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(2'b01, 8'h12, 8'h34, 8'h01, -1);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
